// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_JR, S_JAL,
        S_FAULT
    } state_t;

    // Opcodes (Instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (Instr[5:0])
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_NOR = 4'b0011;
    localparam logic [3:0] ALU_ADD = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    // Datapath mux selects
    localparam logic [1:0] REGDST_RT    = 2'b00;
    localparam logic [1:0] REGDST_RD    = 2'b01;
    localparam logic [1:0] REGDST_R31   = 2'b10;
    localparam logic [1:0] SRCA_PC      = 2'b00;
    localparam logic [1:0] SRCA_A       = 2'b01;
    localparam logic [2:0] SRCB_B       = 3'b000;
    localparam logic [2:0] SRCB_FOUR    = 3'b001;
    localparam logic [2:0] SRCB_IMM     = 3'b010;
    localparam logic [2:0] SRCB_SHAMT   = 3'b011;
    localparam logic [2:0] SRCB_BRIMM   = 3'b100;
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    // Fault causes
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // States that hold a memory request open and may wait on mem_ready
    function automatic logic is_mem_wait(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// Opcode/funct decode to ALU operation, legality and shift/jr flags.
// Latency: purely combinational.
// Backpressure: none.
module mips_alu_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    output logic [3:0] alu_ctrl,
    output logic       op_legal,
    output logic       is_shift,
    output logic       is_jr
);

    // Decode the instruction word fields; unknown encodings are flagged illegal
    always_comb begin
        alu_ctrl = ALU_ADD;
        op_legal = 1'b0;
        is_shift = 1'b0;
        is_jr    = 1'b0;
        case (OpCode)
            OP_RTYPE: begin
                op_legal = 1'b1;
                case (Funct)
                    FN_ADD: alu_ctrl = ALU_ADD;
                    FN_SUB: alu_ctrl = ALU_SUB;
                    FN_AND: alu_ctrl = ALU_AND;
                    FN_OR:  alu_ctrl = ALU_OR;
                    FN_XOR: alu_ctrl = ALU_XOR;
                    FN_NOR: alu_ctrl = ALU_NOR;
                    FN_SLT: alu_ctrl = ALU_SLT;
                    FN_SLL: begin alu_ctrl = ALU_SLL; is_shift = 1'b1; end
                    FN_SRL: begin alu_ctrl = ALU_SRL; is_shift = 1'b1; end
                    FN_SRA: begin alu_ctrl = ALU_SRA; is_shift = 1'b1; end
                    FN_JR:  is_jr = 1'b1;
                    default: op_legal = 1'b0;
                endcase
            end
            OP_ADDI: begin op_legal = 1'b1; alu_ctrl = ALU_ADD; end
            OP_SLTI: begin op_legal = 1'b1; alu_ctrl = ALU_SLT; end
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM with memory wait states, sticky fault and retire counter.
// Latency: lw 5, sw/R/addi/slti 4, branches/jumps 3 cycles, plus one per memory wait cycle.
// Backpressure: mem_req held until mem_ready; waits beyond MEM_TIMEOUT (if nonzero) halt in FAULT.
module mips_mc_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Funct,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             Branch,
    output logic             BranchNE,
    output logic             MemtoReg,
    output logic [1:0]       RegDst,
    output logic [1:0]       ALUSrcA,
    output logic [2:0]       ALUSrcB,
    output logic [1:0]       PCSrc,
    output logic [3:0]       ALUControl,
    output logic             fault,
    output logic [1:0]       fault_cause,
    output logic [CNT_W-1:0] instr_count
);

    // Counter must be able to reach MEM_TIMEOUT itself
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               fault_q, fault_d;
    logic [1:0]         cause_q, cause_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [3:0]  alu_ctrl;
    logic        op_legal, is_shift, is_jr;
    logic        retire, waiting, timeout_hit;
    logic [31:0] wait_next;

    mips_alu_decode u_alu_decode (
        .OpCode   (OpCode),
        .Funct    (Funct),
        .alu_ctrl (alu_ctrl),
        .op_legal (op_legal),
        .is_shift (is_shift),
        .is_jr    (is_jr)
    );

    // A request that is still unanswered after MEM_TIMEOUT cycles is fatal
    assign waiting     = is_mem_wait(state_q) && !mem_ready;
    assign wait_next   = 32'(wait_q) + 32'd1;
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_next == 32'(MEM_TIMEOUT));

    // Next-state, wait counter, fault capture and retire accounting
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        fault_d = fault_q;
        retire  = 1'b0;
        wait_d  = waiting ? wait_q + WAIT_W'(1) : '0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (!op_legal) begin
                    state_d = S_FAULT;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    case (OpCode)
                        OP_LW, OP_SW:     state_d = S_MEMADR;
                        OP_RTYPE:         state_d = is_jr ? S_JR : S_EXEC;
                        OP_ADDI, OP_SLTI: state_d = S_IEXEC;
                        OP_BEQ, OP_BNE:   state_d = S_BRANCH;
                        OP_J:             state_d = S_JUMP;
                        OP_JAL:           state_d = S_JAL;
                        default: begin
                            state_d = S_FAULT;
                            cause_d = CAUSE_ILLEGAL;
                        end
                    endcase
                end
            end
            S_MEMADR: state_d = (OpCode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC:   state_d = S_ALUWB;
            S_IEXEC:  state_d = S_IWB;
            S_MEMWB, S_ALUWB, S_IWB, S_BRANCH, S_JUMP, S_JR, S_JAL: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_FAULT;
        endcase
        if (waiting && timeout_hit) begin
            state_d = S_FAULT;
            cause_d = CAUSE_TIMEOUT;
        end
        if (state_d == S_FAULT) fault_d = 1'b1;
        count_d = retire ? count_q + CNT_W'(1) : count_q;
    end

    // State and bookkeeping registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            fault_q <= 1'b0;
            cause_q <= CAUSE_NONE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            count_q <= count_d;
        end
    end

    // Moore output decode; only fetch completion strobes look at mem_ready
    always_comb begin
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        Branch     = 1'b0;
        BranchNE   = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = REGDST_RT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_B;
        PCSrc      = PCSRC_ALU;
        ALUControl = ALU_ADD;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: ALUSrcB = SRCB_BRIMM;
                S_MEMADR: begin
                    ALUSrcA = SRCA_A;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                S_MEMWR: begin
                    mem_req  = 1'b1;
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA    = SRCA_A;
                    ALUSrcB    = is_shift ? SRCB_SHAMT : SRCB_B;
                    ALUControl = alu_ctrl;
                end
                S_ALUWB: begin
                    RegDst   = REGDST_RD;
                    RegWrite = 1'b1;
                end
                S_IEXEC: begin
                    ALUSrcA    = SRCA_A;
                    ALUSrcB    = SRCB_IMM;
                    ALUControl = alu_ctrl;
                end
                S_IWB: RegWrite = 1'b1;
                S_BRANCH: begin
                    ALUSrcA    = SRCA_A;
                    ALUControl = ALU_SUB;
                    PCSrc      = PCSRC_ALUOUT;
                    Branch     = (OpCode == OP_BEQ);
                    BranchNE   = (OpCode == OP_BNE);
                end
                S_JUMP: begin
                    PCSrc   = PCSRC_JUMP;
                    PCWrite = 1'b1;
                end
                S_JR: begin
                    PCSrc   = PCSRC_REG;
                    PCWrite = 1'b1;
                end
                S_JAL: begin
                    RegDst   = REGDST_R31;
                    RegWrite = 1'b1;
                    PCSrc    = PCSRC_JUMP;
                    PCWrite  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign fault       = fault_q;
    assign fault_cause = cause_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: directed and randomized instruction streams against a trace model.
// Latency: n/a.
// Backpressure: the bench plays the memory, answering each request after a chosen wait.
module tb_mips_mc_ctrl;

    typedef struct packed {
        logic       mem_req, MemWrite, IorD, IRWrite, PCWrite, RegWrite;
        logic       Branch, BranchNE, MemtoReg;
        logic [1:0] RegDst, ALUSrcA;
        logic [2:0] ALUSrcB;
        logic [1:0] PCSrc;
        logic [3:0] ALUControl;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  OpCode = 6'h00;
    logic [5:0]  Funct = 6'h00;
    logic        mem_ready = 1'b0;
    logic        mem_req, MemWrite, IorD, IRWrite, PCWrite, RegWrite;
    logic        Branch, BranchNE, MemtoReg, fault;
    logic [1:0]  RegDst, ALUSrcA, PCSrc, fault_cause;
    logic [2:0]  ALUSrcB;
    logic [3:0]  ALUControl;
    logic [31:0] instr_count;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int model_cnt = 0;
    ctl_t exp_q[$];
    bit   rdy_q[$];

    mips_mc_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .Branch(Branch), .BranchNE(BranchNE),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSrc(PCSrc), .ALUControl(ALUControl), .fault(fault), .fault_cause(fault_cause),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    function automatic ctl_t idle();
        ctl_t c = '0;
        c.ALUControl = 4'b0101;
        return c;
    endfunction

    function automatic ctl_t observe();
        ctl_t c;
        c.mem_req = mem_req;   c.MemWrite = MemWrite; c.IorD = IorD;
        c.IRWrite = IRWrite;   c.PCWrite = PCWrite;   c.RegWrite = RegWrite;
        c.Branch = Branch;     c.BranchNE = BranchNE; c.MemtoReg = MemtoReg;
        c.RegDst = RegDst;     c.ALUSrcA = ALUSrcA;   c.ALUSrcB = ALUSrcB;
        c.PCSrc = PCSrc;       c.ALUControl = ALUControl;
        return c;
    endfunction

    function automatic logic [3:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'h20: return 4'b0101;  6'h22: return 4'b0110;
            6'h24: return 4'b0000;  6'h25: return 4'b0001;
            6'h26: return 4'b0010;  6'h27: return 4'b0011;
            6'h2A: return 4'b0111;  6'h00: return 4'b1001;
            6'h02: return 4'b1000;  6'h03: return 4'b1010;
            default: return 4'b0101;
        endcase
    endfunction

    task automatic check_ctl(input string tag, input ctl_t exp);
        ctl_t got = observe();
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input ctl_t c, input bit r);
        exp_q.push_back(c);
        rdy_q.push_back(r);
    endtask

    // One memory access lasting waits+1 request cycles, answered on the last
    task automatic push_fetch(input int fw);
        ctl_t c;
        for (int i = 0; i <= fw; i++) begin
            c = idle(); c.mem_req = 1'b1; c.ALUSrcB = 3'b001;
            if (i == fw) begin c.IRWrite = 1'b1; c.PCWrite = 1'b1; end
            push(c, i == fw);
        end
        c = idle(); c.ALUSrcB = 3'b100;
        push(c, 1'b0);
    endtask

    // Expected per-cycle trace of one legal instruction
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fw, input int dw);
        ctl_t c;
        exp_q.delete(); rdy_q.delete();
        push_fetch(fw);
        case (op)
            6'h23, 6'h2B: begin
                c = idle(); c.ALUSrcA = 2'b01; c.ALUSrcB = 3'b010; push(c, 1'b0);
                for (int i = 0; i <= dw; i++) begin
                    c = idle(); c.mem_req = 1'b1; c.IorD = 1'b1; c.MemWrite = (op == 6'h2B);
                    push(c, i == dw);
                end
                if (op == 6'h23) begin
                    c = idle(); c.RegWrite = 1'b1; c.MemtoReg = 1'b1; push(c, 1'b0);
                end
            end
            6'h00: begin
                if (fn == 6'h08) begin
                    c = idle(); c.PCSrc = 2'b11; c.PCWrite = 1'b1; push(c, 1'b0);
                end else begin
                    c = idle(); c.ALUSrcA = 2'b01;
                    c.ALUSrcB = (fn inside {6'h00, 6'h02, 6'h03}) ? 3'b011 : 3'b000;
                    c.ALUControl = rtype_alu(fn); push(c, 1'b0);
                    c = idle(); c.RegDst = 2'b01; c.RegWrite = 1'b1; push(c, 1'b0);
                end
            end
            6'h08, 6'h0A: begin
                c = idle(); c.ALUSrcA = 2'b01; c.ALUSrcB = 3'b010;
                c.ALUControl = (op == 6'h0A) ? 4'b0111 : 4'b0101; push(c, 1'b0);
                c = idle(); c.RegWrite = 1'b1; push(c, 1'b0);
            end
            6'h04, 6'h05: begin
                c = idle(); c.ALUSrcA = 2'b01; c.ALUControl = 4'b0110; c.PCSrc = 2'b01;
                c.Branch = (op == 6'h04); c.BranchNE = (op == 6'h05); push(c, 1'b0);
            end
            6'h02: begin
                c = idle(); c.PCSrc = 2'b10; c.PCWrite = 1'b1; push(c, 1'b0);
            end
            default: begin
                c = idle(); c.RegDst = 2'b10; c.RegWrite = 1'b1;
                c.PCSrc = 2'b10; c.PCWrite = 1'b1; push(c, 1'b0);
            end
        endcase
    endtask

    task automatic run_trace(input string tag);
        foreach (exp_q[i]) begin
            @(negedge clk);
            mem_ready = rdy_q[i];
            #1;
            check_ctl($sformatf("%s cyc%0d", tag, i), exp_q[i]);
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input int fw, input int dw);
        OpCode = op;
        Funct  = fn;
        build(op, fn, fw, dw);
        run_trace(tag);
        model_cnt++;
        check_val({tag, " count"}, instr_count, model_cnt);
        check_val({tag, " fault"}, {31'd0, fault}, 32'd0);
    endtask

    // Reset held for two edges; released just after an edge so FETCH starts that cycle
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b0;
        #1;
        check_ctl({tag, " rst out a"}, idle());
        @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check_ctl({tag, " rst out b"}, idle());
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_ready = 1'b0;
        model_cnt = 0;
        #1;
        check_val({tag, " fault"}, {31'd0, fault}, 32'd0);
        check_val({tag, " cause"}, {30'd0, fault_cause}, 32'd0);
        check_val({tag, " count"}, instr_count, 32'd0);
        check_val({tag, " mem_req"}, {31'd0, mem_req}, 32'd1);
    endtask

    // Faulting sequence: prefix already in exp_q, then FAULT cycles with mem_ready noise
    task automatic run_fault(input string tag, input logic [1:0] cause);
        for (int i = 0; i < 3; i++) push(idle(), 1'b1);
        run_trace(tag);
        check_val({tag, " fault"}, {31'd0, fault}, 32'd1);
        check_val({tag, " cause"}, {30'd0, fault_cause}, {30'd0, cause});
        check_val({tag, " count"}, instr_count, model_cnt);
    endtask

    logic [5:0] ops [9]  = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h0A, 6'h04, 6'h05, 6'h02, 6'h03};
    logic [5:0] fns [11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                             6'h00, 6'h02, 6'h03, 6'h08};

    initial begin
        ctl_t c;
        logic [5:0] op, fn;

        do_reset("init");

        run("lw0", 6'h23, 6'h04, 0, 0);
        run("sw3", 6'h2B, 6'h00, 0, 3);
        run("bne", 6'h05, 6'h00, 0, 0);
        run("beq", 6'h04, 6'h00, 0, 0);
        run("jal", 6'h03, 6'h10, 0, 0);
        run("fetch_w3", 6'h00, 6'h20, 3, 0);
        run("lw_w3", 6'h23, 6'h00, 1, 3);
        run("jr", 6'h00, 6'h08, 0, 0);

        for (int k = 0; k < 60; k++) begin
            op = ops[$urandom_range(0, 8)];
            fn = (op == 6'h00) ? fns[$urandom_range(0, 10)] : 6'($urandom);
            run($sformatf("rnd%0d", k), op, fn, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Illegal opcode
        OpCode = 6'h3F; Funct = 6'h00;
        exp_q.delete(); rdy_q.delete();
        push_fetch(0);
        run_fault("ill_op", 2'b01);
        do_reset("after_ill_op");

        // Illegal R-type funct
        OpCode = 6'h00; Funct = 6'h01;
        exp_q.delete(); rdy_q.delete();
        push_fetch(0);
        run_fault("ill_fn", 2'b01);
        do_reset("after_ill_fn");

        // Four unanswered fetch cycles, then a late answer that must be ignored
        OpCode = 6'h23; Funct = 6'h00;
        exp_q.delete(); rdy_q.delete();
        for (int i = 0; i < 4; i++) begin
            c = idle(); c.mem_req = 1'b1; c.ALUSrcB = 3'b001; push(c, 1'b0);
        end
        run_fault("timeout", 2'b10);
        do_reset("after_timeout");

        // Data-side timeout on a load
        run("pre_ld", 6'h08, 6'h00, 0, 0);
        OpCode = 6'h23;
        exp_q.delete(); rdy_q.delete();
        push_fetch(0);
        c = idle(); c.ALUSrcA = 2'b01; c.ALUSrcB = 3'b010; push(c, 1'b0);
        for (int i = 0; i < 4; i++) begin
            c = idle(); c.mem_req = 1'b1; c.IorD = 1'b1; push(c, 1'b0);
        end
        run_fault("ld_timeout", 2'b10);
        do_reset("after_ld_timeout");

        // Reset in the middle of a waiting fetch abandons it
        OpCode = 6'h2B;
        exp_q.delete(); rdy_q.delete();
        for (int i = 0; i < 2; i++) begin
            c = idle(); c.mem_req = 1'b1; c.ALUSrcB = 3'b001; push(c, 1'b0);
        end
        run_trace("mid_fetch");
        do_reset("mid_fetch_rst");
        run("post_rst", 6'h0A, 6'h00, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
